prom_frame_loader: RTL and testbench

- Sits between the UART receiver and the instruction PROM write port; replaces raw byte-pair loading with a framed, checksummed protocol.
- Consumes received bytes through the rx_ready/rx_ack handshake.
- Assembles little-endian 16-bit words and issues one-cycle PROM writes.
- Reports completion, error and load count to the top level.

---
 rtl/prom_frame_loader.sv | 154 +++++++++++++++
 tb/tb_prom_frame_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prom_frame_loader.sv
// Framed PROM loader: accepts 0xA5, N, N little-endian words and a checksum
// byte from the UART receiver, writing each word to the instruction PROM.
module prom_frame_loader #(
    parameter int unsigned ROM_WORDS      = 42,
    parameter int unsigned TIMEOUT_CYCLES = 6250
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     rx_data_i,
    input  logic                           rx_ready_i,
    output logic                           rx_ack_o,
    output logic                           prom_we_o,
    output logic [$clog2(ROM_WORDS)-1:0]   prom_addr_o,
    output logic [15:0]                    prom_data_o,
    output logic                           done_o,
    output logic                           error_o,
    output logic [1:0]                     error_code_o,
    output logic [$clog2(ROM_WORDS+1)-1:0] words_loaded_o
);

    localparam int unsigned AW = $clog2(ROM_WORDS);
    localparam int unsigned CW = $clog2(ROM_WORDS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        COUNT = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        WRITE = 3'd4,
        CHECK = 3'd5
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr;
    logic [CW-1:0]   n_words;
    logic [7:0]      sum;
    logic [7:0]      data_lo;
    logic [TW-1:0]   idle_cnt;

    logic            accept;
    logic [7:0]      sum_next;
    logic [CW-1:0]   wl_next;
    logic            waiting;

    // Handshake, running checksum and word-count helpers
    always_comb begin
        rx_ack_o = (state != WRITE);
        accept   = rx_ready_i && rx_ack_o;
        sum_next = sum + rx_data_i;
        wl_next  = words_loaded_o + 1'b1;
        waiting  = (state == COUNT) || (state == LOW) ||
                   (state == HIGH)  || (state == CHECK);
    end

    // Frame parser, PROM write strobe, status and idle timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= SYNC;
            addr           <= '0;
            n_words        <= '0;
            sum            <= '0;
            data_lo        <= '0;
            idle_cnt       <= '0;
            prom_we_o      <= 1'b0;
            prom_addr_o    <= '0;
            prom_data_o    <= '0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            error_code_o   <= '0;
            words_loaded_o <= '0;
        end else begin
            prom_we_o <= 1'b0;
            if (accept) begin
                idle_cnt <= '0;
            end
            case (state)
                SYNC: begin
                    idle_cnt <= '0;
                    if (accept && rx_data_i == 8'hA5) begin
                        done_o         <= 1'b0;
                        error_o        <= 1'b0;
                        error_code_o   <= 2'd0;
                        words_loaded_o <= '0;
                        sum            <= '0;
                        addr           <= '0;
                        state          <= COUNT;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if (rx_data_i == 8'h00 || 32'(rx_data_i) > ROM_WORDS) begin
                            error_o      <= 1'b1;
                            error_code_o <= 2'd1;
                            state        <= SYNC;
                        end else begin
                            n_words <= CW'(rx_data_i);
                            sum     <= rx_data_i;
                            state   <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (accept) begin
                        data_lo <= rx_data_i;
                        sum     <= sum_next;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    // The strobe, address and data are launched together so the
                    // write is visible for exactly the one WRITE cycle.
                    if (accept) begin
                        sum         <= sum_next;
                        prom_data_o <= {rx_data_i, data_lo};
                        prom_addr_o <= addr;
                        prom_we_o   <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    addr           <= addr + 1'b1;
                    words_loaded_o <= wl_next;
                    state          <= (wl_next == n_words) ? CHECK : LOW;
                end
                CHECK: begin
                    if (accept) begin
                        if (sum_next == 8'h00) begin
                            done_o <= 1'b1;
                        end else begin
                            error_o      <= 1'b1;
                            error_code_o <= 2'd2;
                        end
                        state <= SYNC;
                    end
                end
                default: state <= SYNC;
            endcase
            // An accepted byte always wins over expiry on the same edge.
            if (waiting && !accept) begin
                if (idle_cnt == IDLE_LAST) begin
                    idle_cnt     <= '0;
                    error_o      <= 1'b1;
                    error_code_o <= 2'd3;
                    state        <= SYNC;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prom_frame_loader.sv
// Directed bench for prom_frame_loader: table of whole frames plus hand-written
// timeout and mid-frame reset sequences.
module tb_prom_frame_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_ack;
    logic        prom_we;
    logic [5:0]  prom_addr;
    logic [15:0] prom_data;
    logic        done;
    logic        error;
    logic [1:0]  error_code;
    logic [5:0]  words_loaded;

    int n_cmp = 0;
    int n_err = 0;
    int ack_low = 0;
    logic [5:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    prom_frame_loader #(
        .ROM_WORDS      (42),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data_i      (rx_data),
        .rx_ready_i     (rx_ready),
        .rx_ack_o       (rx_ack),
        .prom_we_o      (prom_we),
        .prom_addr_o    (prom_addr),
        .prom_data_o    (prom_data),
        .done_o         (done),
        .error_o        (error),
        .error_code_o   (error_code),
        .words_loaded_o (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every PROM write and every cycle the loader refuses bytes
    always @(negedge clk) begin
        if (prom_we) begin
            wr_addr.push_back(prom_addr);
            wr_data.push_back(prom_data);
        end
        if (!rx_ack) ack_low++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following acceptance
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_ready = 1'b1;
        while (!rx_ack && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_wait: rx_ack_o stayed 0 for 8 cycles, byte 0x%0h", b);
        end
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    typedef struct {
        int          nb;
        logic [63:0] bytes;
        bit          exp_done;
        bit          exp_err;
        logic [1:0]  exp_code;
        int          exp_wl;
        int          exp_nw;
        logic [15:0] exp_d0;
        logic [15:0] exp_d1;
    } vec_t;

    vec_t        vecs[6];
    logic [63:0] cur;
    int          w0;
    int          a0;

    initial begin
        // First byte of each frame is the most significant byte of 'bytes'
        vecs[0] = '{7, 64'hA502_3412_7856_EA00, 1'b1, 1'b0, 2'd0, 2, 2, 16'h1234, 16'h5678};
        vecs[1] = '{7, 64'hA502_3412_7856_EB00, 1'b0, 1'b1, 2'd2, 2, 2, 16'h1234, 16'h5678};
        vecs[2] = '{2, 64'hA500_0000_0000_0000, 1'b0, 1'b1, 2'd1, 0, 0, 16'h0000, 16'h0000};
        vecs[3] = '{2, 64'hA52B_0000_0000_0000, 1'b0, 1'b1, 2'd1, 0, 0, 16'h0000, 16'h0000};
        vecs[4] = '{8, 64'h00FF_5AA5_01CD_AB87, 1'b1, 1'b0, 2'd0, 1, 1, 16'hABCD, 16'h0000};
        vecs[5] = '{5, 64'hA501_A5A5_B500_0000, 1'b1, 1'b0, 2'd0, 1, 1, 16'hA5A5, 16'h0000};

        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_we",    32'(prom_we),      32'd0);
        check("reset_addr",  32'(prom_addr),    32'd0);
        check("reset_data",  32'(prom_data),    32'd0);
        check("reset_done",  32'(done),         32'd0);
        check("reset_error", 32'(error),        32'd0);
        check("reset_code",  32'(error_code),   32'd0);
        check("reset_wl",    32'(words_loaded), 32'd0);
        check("reset_ack",   32'(rx_ack),       32'd1);

        for (int v = 0; v < 6; v++) begin
            w0  = wr_data.size();
            a0  = ack_low;
            cur = vecs[v].bytes;
            for (int i = 0; i < vecs[v].nb; i++) begin
                send_byte(cur[63 - 8*i -: 8]);
            end
            @(negedge clk);
            check($sformatf("v%0d_done", v),  32'(done),         32'(vecs[v].exp_done));
            check($sformatf("v%0d_error", v), 32'(error),        32'(vecs[v].exp_err));
            check($sformatf("v%0d_code", v),  32'(error_code),   32'(vecs[v].exp_code));
            check($sformatf("v%0d_wl", v),    32'(words_loaded), 32'(vecs[v].exp_wl));
            check($sformatf("v%0d_nw", v),    32'(wr_data.size() - w0), 32'(vecs[v].exp_nw));
            check($sformatf("v%0d_acklow", v), 32'(ack_low - a0), 32'(vecs[v].exp_nw));
            if (vecs[v].exp_nw >= 1 && wr_data.size() > w0) begin
                check($sformatf("v%0d_a0", v), 32'(wr_addr[w0]), 32'd0);
                check($sformatf("v%0d_d0", v), 32'(wr_data[w0]), 32'(vecs[v].exp_d0));
            end
            if (vecs[v].exp_nw >= 2 && wr_data.size() > w0 + 1) begin
                check($sformatf("v%0d_a1", v), 32'(wr_addr[w0 + 1]), 32'd1);
                check($sformatf("v%0d_d1", v), 32'(wr_data[w0 + 1]), 32'(vecs[v].exp_d1));
            end
        end

        // Timeout: 15 idle edges are tolerated, the 16th aborts
        w0 = wr_data.size();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h34);
        repeat (15) @(negedge clk);
        check("to_before_error", 32'(error), 32'd0);
        @(negedge clk);
        check("to_error", 32'(error),      32'd1);
        check("to_code",  32'(error_code), 32'd3);
        check("to_done",  32'(done),       32'd0);
        check("to_nw",    32'(wr_data.size() - w0), 32'd0);

        // Byte arriving on the 16th idle edge wins over expiry
        w0 = wr_data.size();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h34);
        repeat (15) @(negedge clk);
        send_byte(8'h12);
        check("late_error", 32'(error),     32'd0);
        check("late_we",    32'(prom_we),   32'd1);
        check("late_data",  32'(prom_data), 32'h1234);
        send_byte(8'hB9);
        @(negedge clk);
        check("late_done", 32'(done), 32'd1);
        check("late_nw",   32'(wr_data.size() - w0), 32'd1);

        // Reset between low and high byte of word 0
        w0 = wr_data.size();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hCD);
        reset = 1'b1;
        @(negedge clk);
        check("mr_we",    32'(prom_we),      32'd0);
        check("mr_addr",  32'(prom_addr),    32'd0);
        check("mr_data",  32'(prom_data),    32'd0);
        check("mr_done",  32'(done),         32'd0);
        check("mr_error", 32'(error),        32'd0);
        check("mr_wl",    32'(words_loaded), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mr_nw", 32'(wr_data.size() - w0), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hCD);
        send_byte(8'hAB);
        send_byte(8'h87);
        @(negedge clk);
        check("mr2_done", 32'(done), 32'd1);
        check("mr2_nw",   32'(wr_data.size() - w0), 32'd1);
        if (wr_data.size() > w0) begin
            check("mr2_a0", 32'(wr_addr[w0]), 32'd0);
            check("mr2_d0", 32'(wr_data[w0]), 32'hABCD);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
